// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the raster timing generator: per-axis timing
// record, VGA 640x480@60 defaults, and total/validity helpers.
package video_timing_pkg;

    localparam int TIMING_W = 12;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef struct packed {
        logic [TIMING_W-1:0] act;
        logic [TIMING_W-1:0] fp;
        logic [TIMING_W-1:0] sync;
        logic [TIMING_W-1:0] bp;
    } timing_axis_t;

    // Largest total a counter of TIMING_W bits can sweep (0 .. 2^TIMING_W-1).
    localparam logic [TIMING_W+1:0] AXIS_MAX_TOTAL = {2'b01, {TIMING_W{1'b0}}};

    function automatic timing_axis_t make_axis(input int act, input int fp,
                                               input int sync, input int bp);
        timing_axis_t t;
        t.act  = TIMING_W'(act);
        t.fp   = TIMING_W'(fp);
        t.sync = TIMING_W'(sync);
        t.bp   = TIMING_W'(bp);
        return t;
    endfunction

    function automatic logic [TIMING_W:0] axis_total(input timing_axis_t t);
        return {1'b0, t.act} + {1'b0, t.fp} + {1'b0, t.sync} + {1'b0, t.bp};
    endfunction

    // Validity needs two guard bits: four maximal fields overflow TIMING_W+1.
    function automatic logic axis_valid(input timing_axis_t t);
        logic [TIMING_W+1:0] wide;
        wide = {2'b00, t.act} + {2'b00, t.fp} + {2'b00, t.sync} + {2'b00, t.bp};
        return (t.act != '0) && (t.fp != '0) && (t.sync != '0) && (t.bp != '0)
            && (wide <= AXIS_MAX_TOTAL);
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: a wrapping position counter plus active/sync region decode
// for the currently applied timing record.
module video_axis_counter
    import video_timing_pkg::*;
(
    input  logic                pixclk_i,
    input  logic                rst_n_i,
    input  logic                step_i,
    input  timing_axis_t        timing_i,
    output logic [TIMING_W-1:0] cnt_o,
    output logic                wrap_o,
    output logic                in_active_o,
    output logic                in_sync_o
);

    logic [TIMING_W-1:0] cnt_q, cnt_d;
    logic [TIMING_W:0]   total;
    logic [TIMING_W:0]   cnt_ext;
    logic [TIMING_W:0]   sync_start;
    logic [TIMING_W:0]   sync_end;

    assign total      = axis_total(timing_i);
    assign cnt_ext    = {1'b0, cnt_q};
    assign sync_start = {1'b0, timing_i.act} + {1'b0, timing_i.fp};
    assign sync_end   = sync_start + {1'b0, timing_i.sync};

    // >= rather than == keeps the counter recoverable if it ever sits past the end.
    assign wrap_o      = (cnt_ext >= (total - {{TIMING_W{1'b0}}, 1'b1}));
    assign in_active_o = (cnt_q < timing_i.act);
    assign in_sync_o   = (cnt_ext >= sync_start) && (cnt_ext < sync_end);
    assign cnt_o       = cnt_q;

    // NOTE: default assigned first so no path through always_comb infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (step_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + TIMING_W'(1);
        end
    end

    // NOTE: non-blocking so every flop samples pre-edge values, like real hardware.
    always_ff @(posedge pixclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-reconfigurable raster timing generator. New timing is double-buffered
// and swapped in only on the last pixel of a frame. CNT_W must equal TIMING_W.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CNT_W    = TIMING_W,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             pixclk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [CNT_W-1:0] cfg_h_active_i,
    input  logic [CNT_W-1:0] cfg_h_fp_i,
    input  logic [CNT_W-1:0] cfg_h_sync_i,
    input  logic [CNT_W-1:0] cfg_h_bp_i,
    input  logic [CNT_W-1:0] cfg_v_active_i,
    input  logic [CNT_W-1:0] cfg_v_fp_i,
    input  logic [CNT_W-1:0] cfg_v_sync_i,
    input  logic [CNT_W-1:0] cfg_v_bp_i,
    output logic             cfg_pending_o,
    output logic             cfg_err_o,
    output logic             VDEn_o,
    output logic             hSync_o,
    output logic             vSync_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             sof_o,
    output logic             eol_o
);

    localparam timing_axis_t H_DEFAULT = make_axis(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam timing_axis_t V_DEFAULT = make_axis(V_ACTIVE, V_FP, V_SYNC, V_BP);

    timing_axis_t act_h_q, act_h_d, act_v_q, act_v_d;
    timing_axis_t pend_h_q, pend_h_d, pend_v_q, pend_v_d;
    logic         pending_q, pending_d;
    logic         err_q, err_d;

    timing_axis_t        cfg_h, cfg_v;
    logic                cfg_ok;
    logic [TIMING_W-1:0] h_cnt, v_cnt;
    logic                h_wrap, v_wrap, h_in_act, v_in_act, h_in_sync, v_in_sync;
    logic                frame_wrap;

    logic                de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic                sof_q, sof_d, eol_q, eol_d;
    logic [TIMING_W-1:0] x_q, x_d, y_q, y_d;

    video_axis_counter u_h_cnt (
        .pixclk_i    (pixclk_i),
        .rst_n_i     (rst_n_i),
        .step_i      (en_i),
        .timing_i    (act_h_q),
        .cnt_o       (h_cnt),
        .wrap_o      (h_wrap),
        .in_active_o (h_in_act),
        .in_sync_o   (h_in_sync)
    );

    video_axis_counter u_v_cnt (
        .pixclk_i    (pixclk_i),
        .rst_n_i     (rst_n_i),
        .step_i      (en_i && h_wrap),
        .timing_i    (act_v_q),
        .cnt_o       (v_cnt),
        .wrap_o      (v_wrap),
        .in_active_o (v_in_act),
        .in_sync_o   (v_in_sync)
    );

    assign cfg_h      = '{act: cfg_h_active_i, fp: cfg_h_fp_i, sync: cfg_h_sync_i, bp: cfg_h_bp_i};
    assign cfg_v      = '{act: cfg_v_active_i, fp: cfg_v_fp_i, sync: cfg_v_sync_i, bp: cfg_v_bp_i};
    assign cfg_ok     = axis_valid(cfg_h) && axis_valid(cfg_v);
    assign frame_wrap = en_i && h_wrap && v_wrap;

    // Swap first, then capture: a strobe on the wrap cycle becomes the next pending set.
    always_comb begin
        act_h_d   = act_h_q;
        act_v_d   = act_v_q;
        pend_h_d  = pend_h_q;
        pend_v_d  = pend_v_q;
        pending_d = pending_q;
        err_d     = 1'b0;
        if (frame_wrap && pending_q) begin
            act_h_d   = pend_h_q;
            act_v_d   = pend_v_q;
            pending_d = 1'b0;
        end
        if (cfg_valid_i) begin
            if (cfg_ok) begin
                pend_h_d  = cfg_h;
                pend_v_d  = cfg_v;
                pending_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        de_d  = 1'b0;
        hs_d  = !HS_POL;
        vs_d  = !VS_POL;
        x_d   = '0;
        y_d   = '0;
        sof_d = 1'b0;
        eol_d = 1'b0;
        if (en_i) begin
            de_d  = h_in_act && v_in_act;
            hs_d  = h_in_sync ? HS_POL : !HS_POL;
            vs_d  = v_in_sync ? VS_POL : !VS_POL;
            x_d   = de_d ? h_cnt : '0;
            y_d   = de_d ? v_cnt : '0;
            sof_d = (h_cnt == '0) && (v_cnt == '0);
            eol_d = (h_cnt == act_h_q.act - TIMING_W'(1)) && v_in_act;
        end
    end

    always_ff @(posedge pixclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            act_h_q   <= H_DEFAULT;
            act_v_q   <= V_DEFAULT;
            pend_h_q  <= H_DEFAULT;
            pend_v_q  <= V_DEFAULT;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            de_q      <= 1'b0;
            hs_q      <= !HS_POL;
            vs_q      <= !VS_POL;
            x_q       <= '0;
            y_q       <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            act_h_q   <= act_h_d;
            act_v_q   <= act_v_d;
            pend_h_q  <= pend_h_d;
            pend_v_q  <= pend_v_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
        end
    end

    assign cfg_pending_o = pending_q;
    assign cfg_err_o     = err_q;
    assign VDEn_o        = de_q;
    assign hSync_o       = hs_q;
    assign vSync_o       = vs_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign sof_o         = sof_q;
    assign eol_o         = eol_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: one VGA-default instance and one small-default
// instance (short frames so reconfiguration fits), both against integer raster models.
module tb_video_timing_gen;

    localparam int W = 12;
    localparam int SH[4] = '{20, 3, 5, 4};
    localparam int SV[4] = '{12, 2, 3, 2};
    localparam bit S_HS_POL = 1'b1;
    localparam bit S_VS_POL = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, en_v, en_s, cfg_valid;
    logic [W-1:0] cfg_h[4], cfg_v[4];

    logic         v_pend, v_err, v_de, v_hs, v_vs, v_sof, v_eol;
    logic [W-1:0] v_x, v_y;
    logic         s_pend, s_err, s_de, s_hs, s_vs, s_sof, s_eol;
    logic [W-1:0] s_x, s_y;

    video_timing_gen dut_vga (
        .pixclk_i(clk), .rst_n_i(rst_n), .en_i(en_v), .cfg_valid_i(1'b0),
        .cfg_h_active_i('0), .cfg_h_fp_i('0), .cfg_h_sync_i('0), .cfg_h_bp_i('0),
        .cfg_v_active_i('0), .cfg_v_fp_i('0), .cfg_v_sync_i('0), .cfg_v_bp_i('0),
        .cfg_pending_o(v_pend), .cfg_err_o(v_err), .VDEn_o(v_de), .hSync_o(v_hs),
        .vSync_o(v_vs), .x_o(v_x), .y_o(v_y), .sof_o(v_sof), .eol_o(v_eol)
    );

    video_timing_gen #(
        .H_ACTIVE(SH[0]), .H_FP(SH[1]), .H_SYNC(SH[2]), .H_BP(SH[3]),
        .V_ACTIVE(SV[0]), .V_FP(SV[1]), .V_SYNC(SV[2]), .V_BP(SV[3]),
        .HS_POL(S_HS_POL), .VS_POL(S_VS_POL)
    ) dut_s (
        .pixclk_i(clk), .rst_n_i(rst_n), .en_i(en_s), .cfg_valid_i(cfg_valid),
        .cfg_h_active_i(cfg_h[0]), .cfg_h_fp_i(cfg_h[1]), .cfg_h_sync_i(cfg_h[2]), .cfg_h_bp_i(cfg_h[3]),
        .cfg_v_active_i(cfg_v[0]), .cfg_v_fp_i(cfg_v[1]), .cfg_v_sync_i(cfg_v[2]), .cfg_v_bp_i(cfg_v[3]),
        .cfg_pending_o(s_pend), .cfg_err_o(s_err), .VDEn_o(s_de), .hSync_o(s_hs),
        .vSync_o(s_vs), .x_o(s_x), .y_o(s_y), .sof_o(s_sof), .eol_o(s_eol)
    );

    int checks = 0;
    int errors = 0;

    // Small-instance model: raster position, applied and pending timing.
    int act_h[4], act_v[4], pnd_h[4], pnd_v[4];
    int mh, mv;
    bit mpend;
    // VGA-instance model: number of enabled cycles since reset.
    int vn;

    function automatic int sum4(input int a[4]);
        return a[0] + a[1] + a[2] + a[3];
    endfunction

    task automatic check_vec(input string tag, input logic [30:0] got, input logic [30:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        act_h = SH; act_v = SV; pnd_h = SH; pnd_v = SV;
        mh = 0; mv = 0; mpend = 1'b0; vn = 0;
    endtask

    // One clock: predict both instances from the model, sample after the edge, advance.
    task automatic tick();
        int ht, vt, nh, nv, ch, cv, pos, h, v;
        int nact_h[4], nact_v[4], npnd_h[4], npnd_v[4];
        bit ide, ihs, ivs, ok, npend;
        logic [W-1:0] ex, ey;
        logic [30:0] es, ev;

        ht = sum4(act_h); vt = sum4(act_v);
        ide = en_s && (mh < act_h[0]) && (mv < act_v[0]);
        ihs = en_s && (mh >= act_h[0] + act_h[1]) && (mh < act_h[0] + act_h[1] + act_h[2]);
        ivs = en_s && (mv >= act_v[0] + act_v[1]) && (mv < act_v[0] + act_v[1] + act_v[2]);
        ex = ide ? W'(mh) : '0;
        ey = ide ? W'(mv) : '0;
        ok = 1'b1; ch = 0; cv = 0;
        for (int i = 0; i < 4; i++) begin
            if (cfg_h[i] == '0 || cfg_v[i] == '0) ok = 1'b0;
            ch += int'(cfg_h[i]); cv += int'(cfg_v[i]);
        end
        if (ch > 4096 || cv > 4096) ok = 1'b0;

        nh = mh; nv = mv; npend = mpend;
        nact_h = act_h; nact_v = act_v; npnd_h = pnd_h; npnd_v = pnd_v;
        if (en_s) begin
            if (mh == ht - 1) begin
                nh = 0;
                nv = (mv == vt - 1) ? 0 : mv + 1;
                if (mv == vt - 1 && mpend) begin
                    nact_h = pnd_h; nact_v = pnd_v; npend = 1'b0;
                end
            end else begin
                nh = mh + 1;
            end
        end
        if (cfg_valid && ok) begin
            for (int i = 0; i < 4; i++) begin
                npnd_h[i] = int'(cfg_h[i]); npnd_v[i] = int'(cfg_v[i]);
            end
            npend = 1'b1;
        end
        es = {ide, ihs ? S_HS_POL : !S_HS_POL, ivs ? S_VS_POL : !S_VS_POL, ex, ey,
              en_s && mh == 0 && mv == 0, en_s && mh == act_h[0] - 1 && mv < act_v[0],
              npend, cfg_valid && !ok};

        pos = vn % 420000; h = pos % 800; v = pos / 800;
        if (en_v) begin
            ev = {h < 640 && v < 480, !(h >= 656 && h < 752), !(v >= 490 && v < 492),
                  (h < 640 && v < 480) ? W'(h) : W'(0), (h < 640 && v < 480) ? W'(v) : W'(0),
                  pos == 0, h == 639 && v < 480, 1'b0, 1'b0};
        end else begin
            ev = {1'b0, 1'b1, 1'b1, 24'd0, 4'd0};
        end

        @(posedge clk);
        #1;
        check_vec("small", {s_de, s_hs, s_vs, s_x, s_y, s_sof, s_eol, s_pend, s_err}, es);
        check_vec("vga", {v_de, v_hs, v_vs, v_x, v_y, v_sof, v_eol, v_pend, v_err}, ev);

        mh = nh; mv = nv; mpend = npend;
        act_h = nact_h; act_v = nact_v; pnd_h = npnd_h; pnd_v = npnd_v;
        if (en_v) vn++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input int h0, input int h1, input int h2, input int h3,
                          input int v0, input int v1, input int v2, input int v3);
        cfg_h[0] = W'(h0); cfg_h[1] = W'(h1); cfg_h[2] = W'(h2); cfg_h[3] = W'(h3);
        cfg_v[0] = W'(v0); cfg_v[1] = W'(v1); cfg_v[2] = W'(v2); cfg_v[3] = W'(v3);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_vec("rst_small", {s_de, s_hs, s_vs, s_x, s_y, s_sof, s_eol, s_pend, s_err},
                  {1'b0, !S_HS_POL, !S_VS_POL, 24'd0, 4'd0});
        check_vec("rst_vga", {v_de, v_hs, v_vs, v_x, v_y, v_sof, v_eol, v_pend, v_err},
                  {1'b0, 1'b1, 1'b1, 24'd0, 4'd0});
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int rnd_field(input int hi);
        return ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, hi));
    endfunction

    initial begin
        bit found;
        rst_n = 1'b1; en_v = 1'b1; en_s = 1'b1; cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_h[i] = '0; cfg_v[i] = '0;
        end
        model_reset();
        #2;
        do_reset();

        // VGA defaults; enable gap of 37 cycles when the line position reaches 100.
        run(100);
        en_v = 1'b0;
        run(37);
        en_v = 1'b1;
        run(2500);

        // Tiny timing strobed mid-frame; applied at the next frame boundary.
        strobe(4, 1, 2, 1, 3, 1, 1, 1);
        run(800);

        // A random set pending, then a second set strobed on the exact wrap cycle.
        strobe(rnd_field(6) + 1, $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6),
               $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4));
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (mh == sum4(act_h) - 1 && mv == sum4(act_v) - 1) begin
                strobe(5, 2, 3, 1, 4, 1, 2, 1);
                found = 1'b1;
            end else begin
                tick();
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $error("FAIL wrap_search got=timeout exp=wrap within 2000 cycles");
        end
        run(1200);

        // Rejected sets: zero sync width, and a total above 2^CNT_W.
        strobe(4, 1, 0, 1, 3, 1, 1, 1);
        run(3);
        strobe(4095, 4095, 1, 1, 3, 1, 1, 1);
        run(20);

        // Total of exactly 2^CNT_W is legal; overwritten before it can be applied.
        strobe(4, 1, 2, 1, 4093, 1, 1, 1);
        run(5);
        strobe(3, 2, 2, 2, 2, 1, 1, 1);
        run(600);

        // Random enable and configuration traffic.
        for (int i = 0; i < 3000; i++) begin
            en_s = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) begin
                strobe(rnd_field(6), rnd_field(6), rnd_field(6), rnd_field(6),
                       rnd_field(4), rnd_field(4), rnd_field(4), rnd_field(4));
            end else begin
                tick();
            end
        end
        en_s = 1'b1;

        // Reset mid-line with a pending set: pending is dropped, defaults resume.
        strobe(4, 1, 2, 1, 3, 1, 1, 1);
        run(7);
        #3;
        do_reset();
        run(700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised, runtime-reconfigurable raster timing generator for the HDMI/VGA output path; next generation of the fixed 800x525 counter/sync block.
- Produces data-enable, h/v sync with programmable polarity, pixel coordinates and frame/line markers for the framebuffer reader and TMDS encoder.
- Timing set per axis: active, front porch, sync, back porch. The set is double-buffered and changes only at a frame boundary, so no torn frames.

Parameters:
- CNT_W, 12, width of all counters, timing fields and coordinates.
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, reset-default horizontal timing in pixels.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, reset-default vertical timing in lines.
- HS_POL, 0, active level of hSync_o (0 = active-low).
- VS_POL, 0, active level of vSync_o.

Ports:
- pixclk_i  in  1  pixel clock; the only clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  run enable.
- cfg_valid_i  in  1  one-cycle strobe; capture the cfg_* fields.
- cfg_h_active_i, cfg_h_fp_i, cfg_h_sync_i, cfg_h_bp_i  in  CNT_W each  new horizontal timing.
- cfg_v_active_i, cfg_v_fp_i, cfg_v_sync_i, cfg_v_bp_i  in  CNT_W each  new vertical timing.
- cfg_pending_o  out  1  new timing captured, waiting for a frame boundary.
- cfg_err_o  out  1  one-cycle pulse; the offered timing was rejected.
- VDEn_o  out  1  active-video enable.
- hSync_o  out  1  horizontal sync, level set by HS_POL.
- vSync_o  out  1  vertical sync, level set by VS_POL.
- x_o  out  CNT_W  pixel column.
- y_o  out  CNT_W  pixel row.
- sof_o  out  1  start-of-frame pulse.
- eol_o  out  1  end-of-active-line pulse.

Behaviour:
- Timing totals:
  - h_total = h_act + h_fp + h_sync + h_bp; v_total is formed the same way.
  - Totals are computed at CNT_W+1 bits.
  - Line order is active, front porch, sync, back porch. The vertical axis uses the same order.
- Counters:
  - h_cnt runs 0..h_total-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, and itself wraps at v_total-1.
  - Both counters advance only while en_i=1.
- Decode (from the counter state, before the output register):
  - de = (h_cnt < h_act) && (v_cnt < v_act).
  - hs_act = h_cnt in [h_act+h_fp, h_act+h_fp+h_sync).
  - vs_act = v_cnt in [v_act+v_fp, v_act+v_fp+v_sync). This is a whole-line granularity.
- Outputs:
  - All outputs are registered: 1-cycle latency from counter state.
  - hSync_o = hs_act ? HS_POL : ~HS_POL. vSync_o follows the same rule with VS_POL.
  - x_o/y_o = h_cnt/v_cnt when de=1, otherwise 0.
  - sof_o = 1 on the cycle after h_cnt=0, v_cnt=0.
  - eol_o = 1 on the cycle after h_cnt=h_act-1 while v_cnt<v_act.
- Reset (asynchronous, active-low):
  - Counters = 0; active and pending timing = parameter defaults.
  - VDEn_o=0, hSync_o=~HS_POL, vSync_o=~VS_POL.
  - x_o=y_o=0; sof_o=eol_o=cfg_pending_o=cfg_err_o=0.
- en_i=0:
  - Counters hold their position.
  - Next cycle: VDEn_o=0, syncs at inactive level, sof_o=eol_o=0, x_o=y_o=0.
  - On re-enable, counting resumes from the held position with no restart.
- Configuration:
  - cfg_valid_i=1 with every field nonzero and no total overflow: copy fields to the pending set and set cfg_pending_o=1 on the next cycle.
  - Any zero field, or h_total/v_total > 2^CNT_W: discard, pulse cfg_err_o, leave the pending set unchanged.
  - A second valid strobe while pending overwrites the pending set.
- Frame wrap:
  - Condition: en_i=1, h_cnt=h_total-1, v_cnt=v_total-1, cfg_pending_o=1.
  - Action: the active set takes the pending set, counters go to 0, cfg_pending_o clears.
  - First new-timing pixel is at h_cnt=0, v_cnt=0 of the next frame.
- cfg_valid_i on the wrap cycle:
  - The wrap applies the previous pending set.
  - The new values are captured as pending and applied at the following frame.
  - cfg_pending_o stays 1.
- cfg_valid_i while en_i=0 is accepted normally. It is applied at the next wrap after re-enable.

Decomposition:
- video_timing_pkg holds:
  - typedef timing_axis_t {act, fp, sync, bp} at CNT_W bits.
  - VGA 640x480@60 default constants.
  - A function returning the axis total.
- Sub-module video_axis_counter, instantiated twice (h and v):
  - Inputs: a step enable and a timing_axis_t.
  - Outputs: the count, a wrap flag and the in_active / in_sync decodes.

Test Plan:
- Defaults, en_i=1, after reset:
  - h_total=800, v_total=525; sof_o pulses every 420000 cycles.
  - hSync_o is low for output cycles matching h_cnt 656..751; VDEn_o is high 640 of every 800 cycles on lines 0..479.
- cfg h=4/1/2/1, v=3/1/1/1 strobed mid-frame:
  - cfg_pending_o=1 until the frame wrap, then the period becomes 48 cycles.
  - VDEn_o=1 for x=0..3 on y=0..2; eol_o asserts at x=3.
- cfg_valid_i on the exact wrap cycle: the old pending set is applied; the new set is applied one frame later; cfg_pending_o stays high across the wrap.
- cfg with h_sync=0, or with a total exceeding 2^CNT_W: cfg_err_o single pulse; cfg_pending_o and the timing are unchanged.
- en_i low for 37 cycles at h_cnt=100:
  - Outputs go inactive.
  - On re-enable, x_o resumes at 100 one cycle later.
- rst_n_i asserted mid-line with pending config:
  - All outputs immediately go to their reset values; pending is dropped.
  - Defaults (800x525) resume after release.
